// File: rtl/round_ctrl_pkg.sv
// Shared state encoding, tick defaults (50 MHz base) and target sanitizer for round_ctrl.
package round_ctrl_pkg;

    localparam int unsigned TICK_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned DEF_ROUND_TICKS = 50_000_000;
    localparam int unsigned DEF_GAP_TICKS   = 12_500_000;
    localparam int unsigned DEF_MAX_ROUNDS  = 16;
    localparam int unsigned DEF_STEP_TICKS  = 2_500_000;
    localparam int unsigned DEF_MIN_TICKS   = 15_000_000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SHOW = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_OVER = 3'd4;

    // Anything that is not exactly one-hot falls back to the first lamp.
    function automatic logic [2:0] sanitize_target(input logic [2:0] raw);
        logic [2:0] res;
        case (raw)
            3'b001, 3'b010, 3'b100: res = raw;
            default:                res = 3'b001;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/round_ctrl_timer.sv
// round_timer: up-counter with synchronous clear and terminal count at limit-1.
module round_timer
    import round_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [TICK_W-1:0] limit,
    output logic              tc_c
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + TICK_W'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == limit - TICK_W'(1));

endmodule

// File: rtl/round_ctrl.sv
// Reaction-game round sequencer: LOAD target, SHOW lamp, score hit/miss, GAP, repeat.
// Optional macro ROUND_SPEEDUP_EN shrinks the SHOW window after every hit.
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter int unsigned ROUND_TICKS = DEF_ROUND_TICKS,
    parameter int unsigned GAP_TICKS   = DEF_GAP_TICKS,
    parameter int unsigned MAX_ROUNDS  = DEF_MAX_ROUNDS,
    parameter int unsigned STEP_TICKS  = DEF_STEP_TICKS,
    parameter int unsigned MIN_TICKS   = DEF_MIN_TICKS
) (
    input  logic             Sys_Clk,
    input  logic             Sys_Rst,
    input  logic             Start,
    input  logic [2:0]       Rand_3bits,
    input  logic [2:0]       Key,
    output logic [2:0]       Led,
    output logic [CNT_W-1:0] Score,
    output logic [CNT_W-1:0] Miss_Cnt,
    output logic             Hit_Pulse,
    output logic             Miss_Pulse,
    output logic             Game_Over
);

`ifdef ROUND_SPEEDUP_EN
    localparam bit SPEEDUP_EN = 1'b1;
`else
    localparam bit SPEEDUP_EN = 1'b0;
`endif

    localparam logic [TICK_W-1:0] ROUND_W = TICK_W'(ROUND_TICKS);
    localparam logic [TICK_W-1:0] GAP_W   = TICK_W'(GAP_TICKS);
    localparam logic [TICK_W-1:0] STEP_W  = TICK_W'(STEP_TICKS);
    localparam logic [TICK_W-1:0] MIN_W   = TICK_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(MAX_ROUNDS);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]        state_q, state_d;
    logic [2:0]        target_q, target_d;
    logic [2:0]        led_q, led_d;
    logic [CNT_W-1:0]  score_q, score_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]  round_q, round_d;
    logic [TICK_W-1:0] window_q, window_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              game_over_q, game_over_d;
    logic              timer_clr_c;
    logic              tc_c;
    logic [TICK_W-1:0] timer_limit_c;

    // One counter serves both SHOW (window) and GAP; it restarts on every state change.
    assign timer_limit_c = (state_q == ST_GAP) ? GAP_W : window_q;
    assign timer_clr_c   = (state_d != state_q) ||
                           !((state_q == ST_SHOW) || (state_q == ST_GAP));

    round_timer u_timer (
        .clk   (Sys_Clk),
        .rst   (Sys_Rst),
        .clr   (timer_clr_c),
        .limit (timer_limit_c),
        .tc_c  (tc_c)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        score_d      = score_q;
        miss_d       = miss_q;
        round_d      = round_q;
        window_d     = window_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (Start) begin
                    state_d  = ST_LOAD;
                    score_d  = '0;
                    miss_d   = '0;
                    round_d  = '0;
                    window_d = ROUND_W;
                end
            end
            ST_LOAD: begin
                target_d = sanitize_target(Rand_3bits);
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                // A key pressed on the terminal cycle wins over the timeout.
                if (Key == target_q) begin
                    hit_pulse_d = 1'b1;
                    score_d     = (score_q == CNT_MAX) ? score_q : score_q + CNT_W'(1);
                    round_d     = round_q + CNT_W'(1);
                    state_d     = ST_GAP;
                    if (SPEEDUP_EN) begin
                        window_d = (window_q >= MIN_W + STEP_W) ? window_q - STEP_W : MIN_W;
                    end
                end else if ((Key != 3'b000) || tc_c) begin
                    miss_pulse_d = 1'b1;
                    miss_d       = (miss_q == CNT_MAX) ? miss_q : miss_q + CNT_W'(1);
                    round_d      = round_q + CNT_W'(1);
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tc_c) begin
                    state_d = (round_q == LAST_RD) ? ST_OVER : ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        led_d       = (state_d == ST_SHOW) ? target_d : 3'b000;
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge Sys_Clk) begin
        if (Sys_Rst) begin
            state_q      <= ST_IDLE;
            target_q     <= 3'b001;
            led_q        <= 3'b000;
            score_q      <= '0;
            miss_q       <= '0;
            round_q      <= '0;
            window_q     <= ROUND_W;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            led_q        <= led_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
            round_q      <= round_d;
            window_q     <= window_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            game_over_q  <= game_over_d;
        end
    end

    assign Led        = led_q;
    assign Score      = score_q;
    assign Miss_Cnt   = miss_q;
    assign Hit_Pulse  = hit_pulse_q;
    assign Miss_Pulse = miss_pulse_q;
    assign Game_Over  = game_over_q;

endmodule
